// File: rtl/core_data_ram_if.sv
// Data-side bus between the memory stage (requester) and the data RAM (responder).
interface bus_if;
    logic        ren;
    logic        wen;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  bytemask;
    logic [31:0] rdata;

    modport responder (
        input  ren, wen, raddr, waddr, wdata, bytemask,
        output rdata
    );

    modport requester (
        output ren, wen, raddr, waddr, wdata, bytemask,
        input  rdata
    );
endinterface

// File: rtl/core_data_ram.sv
// Core data RAM: 1-cycle reads, posted byte-masked writes via a one-entry store buffer.
// Define CORE_DATA_RAM_ERRCNT_EN to build the saturating out-of-range counter.
module core_data_ram #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    bus_if.responder   bus,
    input  logic       err_clr,
    output logic       err,
    output logic [7:0] err_count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic [31:0]   mem [DEPTH];

    logic [31:0]   roff;
    logic [31:0]   woff;
    logic          r_in;
    logic          w_in;
    logic [AW-1:0] ridx;
    logic [AW-1:0] widx;
    logic          w_take;
    logic          err_hit;

    logic          sb_valid;
    logic [AW-1:0] sb_idx;
    logic [31:0]   sb_data;
    logic [3:0]    sb_mask;

    logic [31:0]   fwd;

    // Range check happens on the offset, so out-of-range never aliases into the array.
    assign roff    = bus.raddr - BASE;
    assign woff    = bus.waddr - BASE;
    assign r_in    = roff < SPAN;
    assign w_in    = woff < SPAN;
    assign ridx    = roff[AW+1:2];
    assign widx    = woff[AW+1:2];
    assign w_take  = bus.wen && w_in;
    assign err_hit = (bus.ren && !r_in) || (bus.wen && !w_in);

    // Newest data wins per lane: array, then pending buffer, then same-cycle write.
    always_comb begin
        fwd = mem[ridx];
        for (int i = 0; i < 4; i++) begin
            if (sb_valid && sb_idx == ridx && sb_mask[i])
                fwd[8*i +: 8] = sb_data[8*i +: 8];
            if (w_take && widx == ridx && bus.bytemask[i])
                fwd[8*i +: 8] = bus.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rdata <= '0;
        end else if (bus.ren) begin
            bus.rdata <= r_in ? fwd : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid <= 1'b0;
            sb_idx   <= '0;
            sb_data  <= '0;
            sb_mask  <= '0;
        end else begin
            sb_valid <= w_take;
            if (w_take) begin
                sb_idx  <= widx;
                sb_data <= bus.wdata;
                sb_mask <= bus.bytemask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sb_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (sb_mask[i])
                    mem[sb_idx][8*i +: 8] <= sb_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_hit) begin
            err <= 1'b1;
        end
    end

`ifdef CORE_DATA_RAM_ERRCNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (err_clr) begin
            cnt <= '0;
        end else if (err_hit && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign err_count = cnt;
`else
    assign err_count = 8'h00;
`endif
endmodule
